// File: rtl/wb_write_buffer_if.sv
// Bundles the write-back buffer's enqueue, register-file write and forwarding signals.
// master drives results and read addresses; slave is the buffer itself.
interface wb_write_buffer_if #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
);
  localparam int CW = $clog2(DEPTH) + 1;

  logic          in_valid;
  logic          in_ready;
  logic [AW-1:0] in_addr;
  logic [DW-1:0] in_data;
  logic          rf_we;
  logic          rf_ready;
  logic [AW-1:0] rf_waddr;
  logic [DW-1:0] rf_wdata;
  logic [AW-1:0] rs_addr;
  logic          rs_hit;
  logic [DW-1:0] rs_data;
  logic [AW-1:0] rt_addr;
  logic          rt_hit;
  logic [DW-1:0] rt_data;
  logic [CW-1:0] count;

  modport master (
    output in_valid, in_addr, in_data, rf_ready, rs_addr, rt_addr,
    input  in_ready, rf_we, rf_waddr, rf_wdata, rs_hit, rs_data, rt_hit, rt_data, count
  );

  modport slave (
    input  in_valid, in_addr, in_data, rf_ready, rs_addr, rt_addr,
    output in_ready, rf_we, rf_waddr, rf_wdata, rs_hit, rs_data, rt_hit, rt_data, count
  );
endinterface

// File: rtl/wb_write_buffer.sv
// Write-back FIFO for the register file: queues results, drains one per cycle,
// and forwards the youngest pending value for the rs/rt read ports.
module wb_write_buffer #(
  parameter int DEPTH = 4,
  parameter int AW    = 5,
  parameter int DW    = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  wb_write_buffer_if.slave  bus
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  logic [AW-1:0] addr_r [DEPTH];
  logic [DW-1:0] data_r [DEPTH];
  logic [PW-1:0] wr_ptr_r;
  logic [PW-1:0] rd_ptr_r;
  logic [CW-1:0] count_r;

  logic          full_s;
  logic          empty_s;
  logic          in_fire_s;
  logic          store_s;
  logic          deq_s;
  logic [DW:0]   rs_fwd_s;
  logic [DW:0]   rt_fwd_s;

  // Scan oldest to youngest so the last match wins; $0 never forwards.
  function automatic logic [DW:0] lookup(input logic [AW-1:0] a);
    logic [DW:0]   res;
    logic [PW-1:0] idx;
    logic          m;
    res = {(DW+1){1'b0}};
    for (int k = 0; k < DEPTH; k++) begin
      idx = rd_ptr_r + PW'(k);
      m   = (CW'(k) < count_r) && (addr_r[idx] == a) && (a != {AW{1'b0}});
      res = m ? {1'b1, data_r[idx]} : res;
    end
    return res;
  endfunction

  assign full_s    = (count_r == CW'(DEPTH));
  assign empty_s   = (count_r == {CW{1'b0}});
  assign in_fire_s = bus.in_valid & ~full_s;
  assign store_s   = in_fire_s & (bus.in_addr != {AW{1'b0}});
  assign deq_s     = ~empty_s & bus.rf_ready;

  // Head entry drives the RF write port; all zero while empty.
  always_comb begin
    bus.in_ready = ~full_s;
    bus.count    = count_r;
    bus.rf_we    = ~empty_s;
    if (empty_s) begin
      bus.rf_waddr = {AW{1'b0}};
      bus.rf_wdata = {DW{1'b0}};
    end else begin
      bus.rf_waddr = addr_r[rd_ptr_r];
      bus.rf_wdata = data_r[rd_ptr_r];
    end
  end

  // Forwarding sees stored entries only, including the one draining this cycle.
  always_comb begin
    rs_fwd_s    = lookup(bus.rs_addr);
    rt_fwd_s    = lookup(bus.rt_addr);
    bus.rs_hit  = rs_fwd_s[DW];
    bus.rs_data = rs_fwd_s[DW-1:0];
    bus.rt_hit  = rt_fwd_s[DW];
    bus.rt_data = rt_fwd_s[DW-1:0];
  end

  // Pointer and occupancy bookkeeping; pointers wrap naturally at DEPTH.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_r <= {PW{1'b0}};
      rd_ptr_r <= {PW{1'b0}};
      count_r  <= {CW{1'b0}};
    end else begin
      if (store_s) begin
        wr_ptr_r <= wr_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      end else begin
        wr_ptr_r <= wr_ptr_r;
      end
      if (deq_s) begin
        rd_ptr_r <= rd_ptr_r + {{(PW-1){1'b0}}, 1'b1};
      end else begin
        rd_ptr_r <= rd_ptr_r;
      end
      count_r <= count_r + {{PW{1'b0}}, store_s} - {{PW{1'b0}}, deq_s};
    end
  end

  // Entry storage, cleared on reset so nothing stale can ever be forwarded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        addr_r[i] <= {AW{1'b0}};
        data_r[i] <= {DW{1'b0}};
      end
    end else if (store_s) begin
      addr_r[wr_ptr_r] <= bus.in_addr;
      data_r[wr_ptr_r] <= bus.in_data;
    end else begin
      addr_r[wr_ptr_r] <= addr_r[wr_ptr_r];
      data_r[wr_ptr_r] <= data_r[wr_ptr_r];
    end
  end
endmodule

// File: tb/tb_wb_write_buffer.sv
// Randomized self-checking bench for wb_write_buffer against a queue-based model.
module tb_wb_write_buffer;
  localparam int DEPTH = 4;
  localparam int AW    = 5;
  localparam int DW    = 32;

  typedef struct packed {
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } ent_t;

  logic clk;
  logic rst_n;
  int   vectors;
  int   miscompares;
  ent_t q[$];

  wb_write_buffer_if #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) bus ();

  wb_write_buffer #(.DEPTH(DEPTH), .AW(AW), .DW(DW)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL %s: observed %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  // Youngest queued value for a register; $0 never hits.
  function automatic logic [DW:0] model_fwd(input logic [AW-1:0] a);
    if (a == 0) return '0;
    for (int i = q.size() - 1; i >= 0; i--)
      if (q[i].a == a) return {1'b1, q[i].d};
    return '0;
  endfunction

  task automatic check_outputs();
    logic [DW:0] f;
    check("count", 64'(bus.count), 64'(q.size()));
    check("in_ready", 64'(bus.in_ready), 64'(q.size() < DEPTH));
    check("rf_we", 64'(bus.rf_we), 64'(q.size() > 0));
    check("rf_waddr", 64'(bus.rf_waddr), (q.size() > 0) ? 64'(q[0].a) : 64'd0);
    check("rf_wdata", 64'(bus.rf_wdata), (q.size() > 0) ? 64'(q[0].d) : 64'd0);
    f = model_fwd(bus.rs_addr);
    check("rs_hit", 64'(bus.rs_hit), 64'(f[DW]));
    check("rs_data", 64'(bus.rs_data), 64'(f[DW-1:0]));
    f = model_fwd(bus.rt_addr);
    check("rt_hit", 64'(bus.rt_hit), 64'(f[DW]));
    check("rt_data", 64'(bus.rt_data), 64'(f[DW-1:0]));
  endtask

  // One cycle: drive at negedge, check before posedge, then advance the model.
  task automatic step(input logic v, input logic [AW-1:0] a, input logic [DW-1:0] d,
                      input logic rdy, input logic [AW-1:0] rs, input logic [AW-1:0] rt);
    logic fire;
    logic deq;
    @(negedge clk);
    bus.in_valid = v;
    bus.in_addr  = a;
    bus.in_data  = d;
    bus.rf_ready = rdy;
    bus.rs_addr  = rs;
    bus.rt_addr  = rt;
    #1;
    check_outputs();
    fire = v && (q.size() < DEPTH);
    deq  = rdy && (q.size() > 0);
    @(posedge clk);
    if (deq) void'(q.pop_front());
    if (fire && a != 0) q.push_back('{a: a, d: d});
  endtask

  initial begin
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    bus.in_valid = 1'b0;
    bus.in_addr  = '0;
    bus.in_data  = '0;
    bus.rf_ready = 1'b0;
    bus.rs_addr  = 5'd5;
    bus.rt_addr  = 5'd6;
    #12;
    check_outputs();
    @(negedge clk);
    rst_n = 1'b1;

    // In-order drain of two results.
    step(1'b1, 5'd5, 32'h11, 1'b1, 5'd5, 5'd6);
    step(1'b1, 5'd6, 32'h22, 1'b1, 5'd5, 5'd6);
    check("t1_head", 64'(bus.rf_waddr), 64'd5);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd6);
    check("t1_second", 64'(bus.rf_wdata), 64'h22);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd5, 5'd6);
    check("t1_count0", 64'(bus.count), 64'd0);

    // Fill while the RF stalls; fifth offer must be ignored.
    for (int i = 0; i < DEPTH + 1; i++)
      step(1'b1, AW'(i + 10), DW'(32'hA000 + i), 1'b0, 5'd12, 5'd14);
    check("t2_full", 64'(bus.in_ready), 64'd0);
    for (int i = 0; i < DEPTH + 1; i++)
      step(1'b0, 5'd0, 32'h0, 1'b1, 5'd12, 5'd14);

    // Youngest of two same-register entries forwards until both drain.
    step(1'b1, 5'd7, 32'hA, 1'b0, 5'd7, 5'd0);
    step(1'b1, 5'd7, 32'hB, 1'b0, 5'd7, 5'd0);
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd0);
    check("t3_fwd", 64'(bus.rs_data), 64'hB);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd0);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd7, 5'd0);
    step(1'b0, 5'd0, 32'h0, 1'b0, 5'd7, 5'd0);
    check("t3_nohit", 64'(bus.rs_hit), 64'd0);

    // $0 writes complete the handshake but store nothing.
    step(1'b1, 5'd0, 32'hFFFF, 1'b1, 5'd0, 5'd0);
    step(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0);
    check("t4_zero", 64'(bus.rf_we), 64'd0);

    // Three pending, then concurrent enqueue/dequeue across the pointer wrap.
    for (int i = 0; i < 3; i++)
      step(1'b1, AW'(i + 1), DW'($urandom), 1'b0, 5'd1, 5'd2);
    for (int i = 0; i < 10; i++)
      step(1'b1, AW'($urandom_range(1, 31)), DW'($urandom), 1'b1,
           AW'($urandom_range(0, 31)), AW'($urandom_range(0, 31)));
    check("t5_count", 64'(bus.count), 64'd3);
    for (int i = 0; i < 4; i++)
      step(1'b0, 5'd0, 32'h0, 1'b1, 5'd0, 5'd0);

    // Asynchronous reset mid-cycle with two pending.
    step(1'b1, 5'd3, 32'h33, 1'b0, 5'd3, 5'd4);
    step(1'b1, 5'd4, 32'h44, 1'b0, 5'd3, 5'd4);
    @(negedge clk);
    bus.in_valid = 1'b0;
    bus.rf_ready = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    q.delete();
    check("t6_we", 64'(bus.rf_we), 64'd0);
    check("t6_count", 64'(bus.count), 64'd0);
    check("t6_hit", 64'(bus.rs_hit), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int i = 0; i < 3; i++)
      step(1'b0, 5'd0, 32'h0, 1'b1, 5'd3, 5'd4);

    // Random traffic on a narrow register range to exercise forwarding.
    for (int i = 0; i < 2000; i++)
      step(1'($urandom_range(0, 1)), AW'($urandom_range(0, 7)), DW'($urandom),
           1'($urandom_range(0, 3) != 0), AW'($urandom_range(0, 7)), AW'($urandom_range(0, 7)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
